// File: rtl/multicycle_ctrl_fsm_if.sv
// Interface between the instruction register / memory side and the
// multi-cycle control FSM.
//   inst       : current instruction register contents
//   mem_ready  : memory acknowledges the current access this cycle
//   state      : current FSM state encoding
//   mem_req    : memory access requested (IF, LD_MEM, ST_MEM)
//   mem_we     : write access (ST_MEM only)
//   ir_load    : IR capture strobe (IF with mem_ready)
//   inst_done  : one-cycle pulse in the last cycle of an instruction
//   illegal_op : one-cycle pulse in ID on an undefined opcode
//   halted     : high while in HALT
//   num_inst   : retired-instruction count
// master = environment driving inst/mem_ready; slave = the FSM.
interface multicycle_ctrl_fsm_if #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 16
);
  logic [WORD_SIZE-1:0] inst;
  logic                 mem_ready;
  logic [3:0]           state;
  logic                 mem_req;
  logic                 mem_we;
  logic                 ir_load;
  logic                 inst_done;
  logic                 illegal_op;
  logic                 halted;
  logic [CNT_W-1:0]     num_inst;

  modport master (
    output inst, mem_ready,
    input  state, mem_req, mem_we, ir_load, inst_done, illegal_op, halted, num_inst
  );

  modport slave (
    input  inst, mem_ready,
    output state, mem_req, mem_we, ir_load, inst_done, illegal_op, halted, num_inst
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Control state machine for the multi-cycle CPU: sequences fetch, decode,
// execute, memory and write-back phases with variable-latency memory
// handshakes, a terminal HALT state, illegal-opcode detection and a
// retired-instruction counter.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : multicycle_ctrl_fsm_if.slave (inst, mem_ready in; state,
//           mem_req, mem_we, ir_load, inst_done, illegal_op, halted,
//           num_inst out)
module multicycle_ctrl_fsm #(
  parameter int WORD_SIZE = 16,
  parameter int OPCODE_W  = 4,
  parameter int FUNC_W    = 6,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_IF     = 4'd1,
    S_ID     = 4'd2,
    S_R_EX   = 4'd3,
    S_I_EX   = 4'd4,
    S_LD_EX  = 4'd5,
    S_ST_EX  = 4'd6,
    S_BR_EX  = 4'd7,
    S_LD_MEM = 4'd8,
    S_ST_MEM = 4'd9,
    S_R_WB   = 4'd10,
    S_I_WB   = 4'd11,
    S_LD_WB  = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_BGZ = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BLZ = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADI = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ORI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_LHI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_LWD = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_SWD = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_JAL = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(15);

  localparam logic [FUNC_W-1:0] FN_JPR = FUNC_W'(25);
  localparam logic [FUNC_W-1:0] FN_JRL = FUNC_W'(26);
  localparam logic [FUNC_W-1:0] FN_WWD = FUNC_W'(28);
  localparam logic [FUNC_W-1:0] FN_HLT = FUNC_W'(29);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]  func;
  logic               illegal_dec;

  logic mem_req, mem_we, ir_load, inst_done, illegal_op, halted;

  // Only the opcode and function fields are decoded; the remaining
  // instruction bits are operands consumed by the datapath.
  logic unused_inst_bits;
  assign unused_inst_bits = ^bus.inst;

  assign opcode = bus.inst[WORD_SIZE-1 -: OPCODE_W];
  assign func   = bus.inst[FUNC_W-1:0];

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    illegal_dec = 1'b0;
    case (state_q)
      S_RST:    state_d = S_IF;
      S_IF:     if (bus.mem_ready) state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_R: begin
            if (func == FN_HLT)
              state_d = S_HALT;
            else if (func == FN_WWD || func == FN_JPR || func == FN_JRL)
              state_d = S_IF;
            else
              state_d = S_R_EX;
          end
          OP_ADI, OP_ORI, OP_LHI:         state_d = S_I_EX;
          OP_LWD:                         state_d = S_LD_EX;
          OP_SWD:                         state_d = S_ST_EX;
          OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: state_d = S_BR_EX;
          OP_JMP, OP_JAL:                 state_d = S_IF;
          default: begin
            state_d     = S_IF;
            illegal_dec = 1'b1;
          end
        endcase
      end
      S_R_EX:   state_d = S_R_WB;
      S_I_EX:   state_d = S_I_WB;
      S_LD_EX:  state_d = S_LD_MEM;
      S_ST_EX:  state_d = S_ST_MEM;
      S_BR_EX:  state_d = S_IF;
      S_LD_MEM: if (bus.mem_ready) state_d = S_LD_WB;
      S_ST_MEM: if (bus.mem_ready) state_d = S_IF;
      S_R_WB, S_I_WB, S_LD_WB: state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;  // unreachable codes recover via fetch
    endcase
  end

  // Output logic
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        ir_load = bus.mem_ready;
      end
      S_ID:     illegal_op = illegal_dec;
      S_LD_MEM: mem_req = 1'b1;
      S_ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_HALT:   halted = 1'b1;
      default: ;
    endcase
    // Retirement is the last cycle before returning to fetch; HLT goes to
    // HALT instead, so it never retires.
    inst_done = (state_q == S_ID || state_q == S_BR_EX || state_q == S_ST_MEM ||
                 state_q == S_R_WB || state_q == S_I_WB || state_q == S_LD_WB) &&
                (state_d == S_IF);
    num_d = inst_done ? num_q + CNT_W'(1) : num_q;
  end

  assign bus.state      = state_q;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.ir_load    = ir_load;
  assign bus.inst_done  = inst_done;
  assign bus.illegal_op = illegal_op;
  assign bus.halted     = halted;
  assign bus.num_inst   = num_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Two instances share the
// stimulus: one with a 16-bit counter and one with a 4-bit counter to
// exercise counter wrap. Each step's expected state, outputs and counts
// are queued up front and popped as the DUT is sampled.
module tb_multicycle_ctrl_fsm;

  localparam logic [3:0] RST = 4'd0, IF = 4'd1, ID = 4'd2, R_EX = 4'd3,
                         I_EX = 4'd4, LD_EX = 4'd5, ST_EX = 4'd6, BR_EX = 4'd7,
                         LD_MEM = 4'd8, ST_MEM = 4'd9, R_WB = 4'd10, I_WB = 4'd11,
                         LD_WB = 4'd12, HALT = 4'd13;

  // {mem_req, mem_we, ir_load, inst_done, illegal_op, halted}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_IF   = 6'b101000;
  localparam logic [5:0] O_IFW  = 6'b100000;
  localparam logic [5:0] O_MEM  = 6'b100000;
  localparam logic [5:0] O_DONE = 6'b000100;
  localparam logic [5:0] O_ST   = 6'b110100;
  localparam logic [5:0] O_ILL  = 6'b000110;
  localparam logic [5:0] O_HALT = 6'b000001;

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic [15:0] inst;
    logic [3:0]  st;
    logic [5:0]  o;
    logic [15:0] n;
  } step_t;

  logic clk;
  logic reset;
  step_t q[$];
  int unsigned n_asserts;
  int unsigned n_fails;
  int unsigned n;

  multicycle_ctrl_fsm_if #(.WORD_SIZE(16), .CNT_W(16)) bus16 ();
  multicycle_ctrl_fsm_if #(.WORD_SIZE(16), .CNT_W(4))  bus4 ();

  assign bus4.inst      = bus16.inst;
  assign bus4.mem_ready = bus16.mem_ready;

  multicycle_ctrl_fsm #(.WORD_SIZE(16), .OPCODE_W(4), .FUNC_W(6), .CNT_W(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  multicycle_ctrl_fsm #(.WORD_SIZE(16), .OPCODE_W(4), .FUNC_W(6), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ex(input logic r, input logic m, input logic [15:0] i,
                    input logic [3:0] s, input logic [5:0] o, input int unsigned cnt);
    step_t e;
    e.rst  = r;
    e.mr   = m;
    e.inst = i;
    e.st   = s;
    e.o    = o;
    e.n    = cnt[15:0];
    q.push_back(e);
  endtask

  initial begin
    step_t e;
    logic [5:0] obs_o;
    int unsigned step;
    n_asserts = 0;
    n_fails   = 0;
    step      = 0;
    reset           = 1'b1;
    bus16.mem_ready = 1'b0;
    bus16.inst      = 16'h0000;
    repeat (2) @(posedge clk);

    n = 0;
    // ADI, memory always ready
    ex(0, 1, 16'h4000, RST,  O_NONE, n);
    ex(0, 1, 16'h4000, IF,   O_IF,   n);
    ex(0, 1, 16'h4000, ID,   O_NONE, n);
    ex(0, 1, 16'h4000, I_EX, O_NONE, n);
    ex(0, 1, 16'h4000, I_WB, O_DONE, n);
    n++;
    ex(1, 1, 16'h4000, IF,   O_IF,   n);
    n = 0;
    // LWD with 3 fetch waits and 2 memory waits
    ex(0, 0, 16'h7000, RST,    O_NONE, n);
    for (int i = 0; i < 3; i++) ex(0, 0, 16'h7000, IF, O_IFW, n);
    ex(0, 1, 16'h7000, IF,     O_IF,   n);
    ex(0, 0, 16'h7000, ID,     O_NONE, n);
    ex(0, 0, 16'h7000, LD_EX,  O_NONE, n);
    ex(0, 0, 16'h7000, LD_MEM, O_MEM,  n);
    ex(0, 0, 16'h7000, LD_MEM, O_MEM,  n);
    ex(0, 1, 16'h7000, LD_MEM, O_MEM,  n);
    ex(0, 0, 16'h7000, LD_WB,  O_DONE, n);
    n++;
    // SWD, no waits
    ex(0, 1, 16'h8000, IF,     O_IF,   n);
    ex(0, 1, 16'h8000, ID,     O_NONE, n);
    ex(0, 1, 16'h8000, ST_EX,  O_NONE, n);
    ex(0, 1, 16'h8000, ST_MEM, O_ST,   n);
    n++;
    // Illegal opcode 11
    ex(0, 1, 16'hB000, IF, O_IF,  n);
    ex(0, 1, 16'hB000, ID, O_ILL, n);
    n++;
    // Plain R-type ALU op
    ex(0, 1, 16'hF000, IF,   O_IF,   n);
    ex(0, 1, 16'hF000, ID,   O_NONE, n);
    ex(0, 1, 16'hF000, R_EX, O_NONE, n);
    ex(0, 1, 16'hF000, R_WB, O_DONE, n);
    n++;
    // Reset while LD_MEM waits
    ex(0, 1, 16'h7000, IF,     O_IF,   n);
    ex(0, 0, 16'h7000, ID,     O_NONE, n);
    ex(0, 0, 16'h7000, LD_EX,  O_NONE, n);
    ex(0, 0, 16'h7000, LD_MEM, O_MEM,  n);
    ex(1, 0, 16'h7000, LD_MEM, O_MEM,  n);
    n = 0;
    // HLT, then HALT holds while mem_ready toggles; reset leaves it
    ex(0, 1, 16'hF01D, RST, O_NONE, n);
    ex(0, 1, 16'hF01D, IF,  O_IF,   n);
    ex(0, 1, 16'hF01D, ID,  O_NONE, n);
    for (int i = 0; i < 20; i++) ex(0, logic'(i % 2), 16'hF01D, HALT, O_HALT, n);
    ex(1, 1, 16'hF01D, HALT, O_HALT, n);
    n = 0;
    // Branch, then WWD
    ex(0, 1, 16'h1000, RST,   O_NONE, n);
    ex(0, 1, 16'h1000, IF,    O_IF,   n);
    ex(0, 1, 16'h1000, ID,    O_NONE, n);
    ex(0, 1, 16'h1000, BR_EX, O_DONE, n);
    n++;
    ex(0, 1, 16'hF01C, IF, O_IF,   n);
    ex(0, 1, 16'hF01C, ID, O_DONE, n);
    n++;
    ex(1, 1, 16'h9000, IF, O_IF,   n);
    n = 0;
    // 16 back-to-back JMPs: 4-bit counter wraps 15 -> 0
    ex(0, 1, 16'h9000, RST, O_NONE, n);
    for (int k = 0; k < 16; k++) begin
      ex(0, 1, 16'h9000, IF, O_IF,   n);
      ex(0, 1, 16'h9000, ID, O_DONE, n);
      n++;
    end
    ex(0, 1, 16'h9000, IF, O_IF, n);

    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      reset           = e.rst;
      bus16.mem_ready = e.mr;
      bus16.inst      = e.inst;
      #1;
      obs_o = {bus16.mem_req, bus16.mem_we, bus16.ir_load,
               bus16.inst_done, bus16.illegal_op, bus16.halted};

      n_asserts++;
      assert (bus16.state === e.st) else begin
        n_fails++;
        $error("FAIL state step %0d: got %0d want %0d", step, bus16.state, e.st);
      end
      n_asserts++;
      assert (obs_o === e.o) else begin
        n_fails++;
        $error("FAIL outputs step %0d: got %b want %b", step, obs_o, e.o);
      end
      n_asserts++;
      assert (bus16.num_inst === e.n) else begin
        n_fails++;
        $error("FAIL num_inst step %0d: got %0d want %0d", step, bus16.num_inst, e.n);
      end
      n_asserts++;
      assert (bus4.num_inst === e.n[3:0]) else begin
        n_fails++;
        $error("FAIL num_inst_w4 step %0d: got %0d want %0d", step, bus4.num_inst, e.n[3:0]);
      end
      n_asserts++;
      assert (bus4.state === e.st) else begin
        n_fails++;
        $error("FAIL state_w4 step %0d: got %0d want %0d", step, bus4.state, e.st);
      end
      step++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
